queue_serial_tx: RTL and testbench

Transmit-side counterpart to the receive-task queue writer. Upstream pushes words with a strobe into a small circular queue (head/tail pointers). A transmitter FSM pops each word and sends it on a single serial line as an asynchronous-style frame: start bit, WIDTH data bits LSB first, stop bit.
Sits between the block-level producer and the off-block serial link.

---
 rtl/queue_tx_pkg.sv | 15 +
 rtl/queue_store.sv | 47 ++++
 rtl/queue_serial_tx.sv | 108 ++++++++++
 tb/tb_queue_serial_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_tx_pkg.sv
// queue_tx_pkg: shared state encoding and sizing helpers for the queued serial transmitter.
package queue_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Pointer width carries one extra wrap bit above the index bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int frame_len(input int width, input int bit_cycles);
    return (width + 2) * bit_cycles;
  endfunction

endpackage

// File: rtl/queue_store.sv
// queue_store: circular word buffer with wrap-bit pointers, occupancy flags and sticky drop flag.
module queue_store
  import queue_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             qfull,
  output logic             qempty,
  output logic [PW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             accept;

  assign qempty   = head == tail;
  assign qfull    = head[AW-1:0] == tail[AW-1:0] && head[AW] != tail[AW];
  assign count    = head - tail;
  assign pop_data = mem[tail[AW-1:0]];
  // Full is judged on registered state, so a same-cycle pop never rescues a push.
  assign accept   = push && !qfull;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) head <= head + 1'b1;
      if (push && qfull) overflow <= 1'b1;
      if (pop && !qempty) tail <= tail + 1'b1;
    end

  always_ff @(posedge clock)
    if (accept) mem[head[AW-1:0]] <= push_data;

endmodule

// File: rtl/queue_serial_tx.sv
// queue_serial_tx: queued words sent as start / WIDTH data bits LSB first / stop frames on one line.
module queue_serial_tx
  import queue_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 2,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_new,
  input  logic [WIDTH-1:0] wr_data,
  output logic             qfull,
  output logic             qempty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             tx_line,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [CW-1:0]    cyc, cyc_n;
  logic [BW-1:0]    bitn, bitn_n;
  logic [WIDTH-1:0] shift, shift_n, pop_data;
  logic             pop, bit_end, tx_line_n;

  queue_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_new),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (pop_data),
    .qfull    (qfull),
    .qempty   (qempty),
    .count    (count),
    .overflow (overflow)
  );

  assign bit_end = cyc == CYC_LAST;
  assign tx_busy = state != IDLE;
  assign tx_done = state == STOP && bit_end;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bitn    <= '0;
      shift   <= '0;
      tx_line <= 1'b1;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bitn    <= bitn_n;
      shift   <= shift_n;
      tx_line <= tx_line_n;
    end

  always_comb begin
    state_n = state;
    cyc_n   = bit_end ? '0 : cyc + 1'b1;
    bitn_n  = bitn;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cyc_n = '0;
        if (!qempty) begin
          pop     = 1'b1;
          shift_n = pop_data;
          state_n = START;
        end
      end
      START:
        if (bit_end) begin
          state_n = DATA;
          bitn_n  = '0;
        end
      DATA:
        if (bit_end) begin
          if (bitn == BIT_LAST) state_n = STOP;
          else begin
            bitn_n  = bitn + 1'b1;
            shift_n = shift >> 1;
          end
        end
      STOP:
        // Back-to-back frames: a waiting word goes straight to START.
        if (bit_end) begin
          if (!qempty) begin
            pop     = 1'b1;
            shift_n = pop_data;
            state_n = START;
          end else state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    tx_line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end

endmodule

// File: tb/tb_queue_serial_tx.sv
// tb_queue_serial_tx: scoreboarded bench; a line monitor decodes frames and checks them against pushed words.
module tb_queue_serial_tx;
  import queue_tx_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int BC = 2;

  logic clock, reset, wr_new;
  logic [W-1:0] wr_data;
  logic qfull, qempty, overflow, tx_line, tx_busy, tx_done;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_got, mon_exp;
  bit mon_abort;

  queue_serial_tx #(.WIDTH(W), .DEPTH(D), .BIT_CYCLES(BC)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_new  (wr_new),
    .wr_data (wr_data),
    .qfull   (qfull),
    .qempty  (qempty),
    .count   (count),
    .overflow(overflow),
    .tx_line (tx_line),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Frame decoder: start detected at a falling line, each bit sampled in its first cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_line === 1'b0 && reset === 1'b0) begin
        mon_abort = 0;
        for (int i = 0; i < W; i++) begin
          repeat (BC) @(negedge clock);
          mon_abort = mon_abort | reset;
          mon_got[i] = tx_line;
        end
        repeat (BC) @(negedge clock);
        mon_abort = mon_abort | reset;
        if (!mon_abort) begin
          tests++;
          if (tx_line !== 1'b1 || tx_done !== 1'b0) begin
            fails++;
            $display("FAIL stop_first: line=%b done=%b, expected line=1 done=0", tx_line, tx_done);
          end
          @(negedge clock);
          tests++;
          if (tx_line !== 1'b1 || tx_done !== 1'b1) begin
            fails++;
            $display("FAIL stop_last: line=%b done=%b, expected line=1 done=1", tx_line, tx_done);
          end
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL frame_data: got unexpected frame %h, expected none", mon_got);
          end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
              fails++;
              $display("FAIL frame_data: got %h, expected %h", mon_got, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit n, input logic [W-1:0] d);
    wr_new = n;
    wr_data = d;
    @(posedge clock);
    #1;
    wr_new = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || tx_busy) && n < 600) begin
      @(posedge clock);
      #1;
      n++;
    end
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL %s_drain: %0d words outstanding busy=%b, expected 0 and idle", name, sb.size(), tx_busy);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    bit bad = 0;
    reset = 1;
    wr_new = 0;
    wr_data = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (tx_line !== 1 || tx_busy !== 0 || qempty !== 1 || qfull !== 0 || count !== 3'd0 ||
          overflow !== 0 || tx_done !== 0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_hold: line=%b busy=%b empty=%b full=%b count=%0d ovf=%b, expected 1 0 1 0 0 0",
               tx_line, tx_busy, qempty, qfull, count, overflow);
    end
  endtask

  task automatic test_single;
    logic [W-1:0] d = 8'hA5;
    logic el, ed, eb;
    int bad_line = 0, bad_ctl = 0;
    sb.push_back(d);
    drive(1, d);
    tests++;
    if (count !== 3'd1) begin
      fails++;
      $display("FAIL single_count: got %0d, expected 1", count);
    end
    for (int c = 1; c <= 21; c++) begin
      @(posedge clock);
      @(negedge clock);
      el = c <= 2 ? 1'b0 : c <= 18 ? d[(c-3)/2] : 1'b1;
      ed = c == 20;
      eb = c <= 20;
      if (tx_line !== el) bad_line++;
      if (tx_done !== ed || tx_busy !== eb) bad_ctl++;
    end
    tests++;
    if (bad_line != 0) begin
      fails++;
      $display("FAIL single_wave: %0d cycles with wrong line, expected 0", bad_line);
    end
    tests++;
    if (bad_ctl != 0) begin
      fails++;
      $display("FAIL single_ctl: %0d cycles with wrong done/busy, expected 0", bad_ctl);
    end
    wait_idle("single");
  endtask

  task automatic test_back_to_back;
    int bad_busy = 0;
    sb.push_back(8'h11);
    for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
    for (int c = 0; c <= 101; c++) begin
      drive(c == 0 || (c >= 3 && c <= 7), c == 0 ? 8'h11 : 8'(c - 2));
      if (c == 7) begin
        tests++;
        if (qfull !== 1 || count !== 3'd4 || overflow !== 1) begin
          fails++;
          $display("FAIL b2b_full: full=%b count=%0d ovf=%b, expected 1 4 1", qfull, count, overflow);
        end
      end
      if (c == 21) begin
        tests++;
        if (tx_line !== 0) begin
          fails++;
          $display("FAIL b2b_gap: line=%b at second start, expected 0", tx_line);
        end
      end
      if (c >= 1 && c <= 100 && tx_busy !== 1) bad_busy++;
      if (c == 101) begin
        tests++;
        if (bad_busy != 0 || tx_busy !== 0) begin
          fails++;
          $display("FAIL b2b_busy: %0d idle cycles inside, busy at end=%b, expected 0 and 0", bad_busy, tx_busy);
        end
      end
    end
    wait_idle("b2b");
    tests++;
    if (overflow !== 1) begin
      fails++;
      $display("FAIL b2b_sticky: ovf=%b, expected 1", overflow);
    end
  endtask

  task automatic test_abort;
    int bad = 0;
    drive(1, 8'h55);
    drive(1, 8'h66);
    drive(1, 8'h77);
    repeat (5) drive(0, 0);
    tests++;
    if (count !== 3'd2 || tx_busy !== 1) begin
      fails++;
      $display("FAIL abort_pre: count=%0d busy=%b, expected 2 1", count, tx_busy);
    end
    #2 reset = 1;
    #1;
    tests++;
    if (tx_line !== 1 || tx_busy !== 0 || count !== 3'd0 || qempty !== 1 || overflow !== 0) begin
      fails++;
      $display("FAIL abort_now: line=%b busy=%b count=%0d empty=%b ovf=%b, expected 1 0 0 1 0",
               tx_line, tx_busy, count, qempty, overflow);
    end
    repeat (3) @(posedge clock);
    #3 reset = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (tx_line !== 1 || tx_busy !== 0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL abort_quiet: %0d active cycles after reset, expected 0", bad);
    end
    sb.push_back(8'h5A);
    drive(1, 8'h5A);
    wait_idle("abort");
  endtask

  task automatic test_stream;
    int n;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (qfull && n < 100) begin
        @(posedge clock);
        #1;
        n++;
      end
      if (n >= 100) begin
        tests++;
        fails++;
        $display("FAIL stream_wait: queue stuck full at word %0d, expected space", i);
      end
      sb.push_back(8'h30 + 8'(i));
      drive(1, 8'h30 + 8'(i));
    end
    wait_idle("stream");
    tests++;
    if (overflow !== 0) begin
      fails++;
      $display("FAIL stream_ovf: ovf=%b, expected 0", overflow);
    end
  endtask

  task automatic test_full_pop;
    sb.push_back(8'hC0);
    drive(1, 8'hC0);
    drive(0, 0);
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'hC0 + 8'(i));
      drive(1, 8'hC0 + 8'(i));
    end
    repeat (15) drive(0, 0);
    tests++;
    if (count !== 3'd4 || qfull !== 1 || overflow !== 0) begin
      fails++;
      $display("FAIL fullpop_pre: count=%0d full=%b ovf=%b, expected 4 1 0", count, qfull, overflow);
    end
    drive(1, 8'hEE);
    tests++;
    if (count !== 3'd3 || qfull !== 0 || overflow !== 1) begin
      fails++;
      $display("FAIL fullpop_drop: count=%0d full=%b ovf=%b, expected 3 0 1", count, qfull, overflow);
    end
    wait_idle("fullpop");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_stream();
    test_full_pop();
    repeat (frame_len(W, BC)) @(posedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_sb: %0d words untransmitted, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
